// File: rtl/mips_pc_unit.sv
// Program-counter stage of the single-cycle MIPS core.
// Holds the PC, produces PC+4, selects the next PC from four sources and
// redirects misaligned control-flow targets to an exception vector after a
// one-cycle TRAP state. A one-cycle BOOT state follows every reset release.
module mips_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCsum,
    output logic        FetchValid,
    output logic        Trap,
    output logic [31:0] EPC,
    output logic [31:0] BadAddr,
    output logic [7:0]  TrapCount
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'b00,
        SRC_BRANCH = 2'b01,
        SRC_JUMP   = 2'b10,
        SRC_REG    = 2'b11
    } pc_src_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] bad_q, bad_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] candidate;

    // Sequential address; wraps silently at the top of the address space.
    assign PCsum = pc_q + 32'd4;

    // Next-PC source mux.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        candidate = PCsum;
        case (pc_src_t'(PCSrc))
            SRC_SEQ:    candidate = PCsum;
            SRC_BRANCH: candidate = BranchTarget;
            SRC_JUMP:   candidate = JumpTarget;
            SRC_REG:    candidate = RegTarget;
            default:    candidate = PCsum;
        endcase
    end

    // Next-state logic: hold by default, step only in RUN when not stalled.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: begin
                // Instruction memory settle cycle; inputs are ignored.
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!Stall) begin
                    if (candidate[1:0] == 2'b00) begin
                        pc_d = candidate;
                    end else begin
                        epc_d   = pc_q;
                        bad_d   = candidate;
                        pc_d    = EXC_VECTOR;
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: begin
                // PC already holds EXC_VECTOR; handler fetch starts next cycle.
                state_d = S_RUN;
            end
            default: begin
                state_d = S_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'd0;
            bad_q   <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs decoded from the state.
    assign FetchValid = (state_q == S_RUN);
    assign Trap       = (state_q == S_TRAP);
    assign PC         = pc_q;
    assign EPC        = epc_q;
    assign BadAddr    = bad_q;
    assign TrapCount  = cnt_q;

endmodule
